// File: rtl/mul_sched_pkg.sv
// Shared types, default sizes and the round-robin index helper for the
// shared multiplier scheduler.
package mul_sched_pkg;

  localparam int WIDTH_LOG = 2;
  localparam int WIDTH     = 1 << WIDTH_LOG;
  localparam int OUT_WIDTH = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESP
  } state_t;

  // Requester examined at position 'offset' of the search that starts just after 'last'.
  function automatic int rr_idx(input int last, input int offset, input int nreq);
    return (last + 1 + offset) % nreq;
  endfunction

endpackage

// File: rtl/mul_step_core.sv
// Shift-and-add multiplier datapath: one conditional add of the shifted
// multiplicand per step, with optional early termination.
module mul_step_core #(
  parameter int WIDTH_LOG  = 2,
  parameter bit CONST_TIME = 1'b0,
  localparam int WIDTH     = 1 << WIDTH_LOG,
  localparam int OUT_WIDTH = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] acc
);

  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH_LOG:0]   cnt;
  logic [OUT_WIDTH-1:0] a_ext;
  logic [OUT_WIDTH-1:0] addend;

  assign a_ext  = {{WIDTH{1'b0}}, a_reg};
  assign addend = b_reg[0] ? (a_ext << cnt) : '0;

  // Early termination watches b_reg as it shifts, so the step count tracks
  // the msb of the original b rather than always running WIDTH steps.
  always_comb begin
    done = 1'b0;
    if (CONST_TIME) begin
      done = (cnt == (WIDTH_LOG + 1)'(WIDTH));
    end else begin
      done = (cnt == (WIDTH_LOG + 1)'(WIDTH)) || (a_reg == '0) || (b_reg == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (load) begin
      a_reg <= a_in;
      b_reg <= b_in;
      acc   <= '0;
      cnt   <= '0;
    end else if (step && !done) begin
      acc   <= acc + addend;
      b_reg <= b_reg >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one shift-and-add multiplier between NREQ
// requesters; each product is returned tagged with its requester index.
module mul_share_sched #(
  parameter int WIDTH_LOG  = mul_sched_pkg::WIDTH_LOG,
  parameter int NREQ       = 4,
  parameter int IDW        = $clog2(NREQ),
  parameter bit CONST_TIME = 1'b0,
  localparam int WIDTH     = 1 << WIDTH_LOG,
  localparam int OUT_WIDTH = 2 * WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [OUT_WIDTH-1:0]  rsp_o,
  output logic                  busy
);

  import mul_sched_pkg::*;

  state_t               state;
  logic [IDW-1:0]       last;
  logic [IDW-1:0]       id_reg;
  logic [IDW-1:0]       cand;
  logic [IDW-1:0]       grant_idx;
  logic                 grant_found;
  logic                 grant_en;
  logic                 load;
  logic                 step;
  logic                 core_done;
  logic [OUT_WIDTH-1:0] core_acc;
  logic [WIDTH-1:0]     a_sel;
  logic [WIDTH-1:0]     b_sel;

  // First valid requester after the previous winner, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'(rr_idx(int'(last), k, NREQ));
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Held low during reset so a requester already asserting valid sees no accept.
  assign grant_en = rst_n && (state == IDLE) && grant_found;
  assign load     = grant_en;
  assign step     = (state == COMPUTE);
  assign busy     = (state != IDLE);
  assign a_sel    = req_a[grant_idx*WIDTH +: WIDTH];
  assign b_sel    = req_b[grant_idx*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (grant_en) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  mul_step_core #(
    .WIDTH_LOG  (WIDTH_LOG),
    .CONST_TIME (CONST_TIME)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .a_in  (a_sel),
    .b_in  (b_sel),
    .done  (core_done),
    .acc   (core_acc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= IDW'(NREQ - 1);
      id_reg    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            id_reg <= grant_idx;
            last   <= grant_idx;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (core_done) begin
            rsp_o     <= core_acc;
            rsp_id    <= id_reg;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_sched.sv
// Self-checking bench for mul_share_sched: directed and random transactions
// compared against an arithmetic model of grant order, latency and product.
module tb_mul_share_sched;

  localparam int W    = mul_sched_pkg::WIDTH;
  localparam int OW   = mul_sched_pkg::OUT_WIDTH;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [OW-1:0]     rsp_o;
  logic              busy;

  logic [NREQ-1:0]   v1;
  logic [NREQ-1:0]   rdy1;
  logic [NREQ*W-1:0] a1;
  logic [NREQ*W-1:0] b1;
  logic              rv1;
  logic              rr1;
  logic [IDW-1:0]    rid1;
  logic [OW-1:0]     ro1;
  logic              busy1;

  int checks = 0;
  int errors = 0;
  int last_m = NREQ - 1;

  always #5 clk = ~clk;

  mul_share_sched #(.NREQ(NREQ), .CONST_TIME(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_o     (rsp_o),
    .busy      (busy)
  );

  mul_share_sched #(.NREQ(NREQ), .CONST_TIME(1'b1)) dut_ct (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (v1),
    .req_ready (rdy1),
    .req_a     (a1),
    .req_b     (b1),
    .rsp_valid (rv1),
    .rsp_ready (rr1),
    .rsp_id    (rid1),
    .rsp_o     (ro1),
    .busy      (busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ*W-1:0] abus,
                               input logic [NREQ*W-1:0] bbus);
    req_valid = valid;
    req_a     = abus;
    req_b     = bbus;
  endtask

  // Next winner: first valid requester after the last one served, wrapping around.
  function automatic int modelGrant();
    for (int off = 1; off <= NREQ; off++) begin
      if (req_valid[(last_m + off) % NREQ]) return (last_m + off) % NREQ;
    end
    return -1;
  endfunction

  function automatic int modelSteps(input logic [W-1:0] a, input logic [W-1:0] b, input bit ct);
    if (ct) return W;
    if (a == 0 || b == 0) return 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 0;
  endfunction

  // One full transaction on the main DUT; entered mid-cycle with inputs applied and the DUT idle.
  task automatic runTxn(input string tag, input int stall);
    int g;
    int k;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic leak;
    #1;
    g = modelGrant();
    a = req_a[g*W +: W];
    b = req_b[g*W +: W];
    checkOutput({tag, "_grant"}, 32'(req_ready), 32'(1 << g));
    last_m    = g;
    rsp_ready = (stall == 0);
    k    = 0;
    leak = 1'b0;
    do begin
      @(negedge clk);
      #1;
      k++;
      if (!rsp_valid) leak = leak | (|req_ready) | !busy;
    end while (!rsp_valid && k < 40);
    checkOutput({tag, "_lat"}, 32'(k), 32'(modelSteps(a, b, 1'b0) + 2));
    checkOutput({tag, "_prod"}, 32'(rsp_o), 32'(a) * 32'(b));
    checkOutput({tag, "_id"}, 32'(rsp_id), 32'(g));
    checkOutput({tag, "_compute_flags"}, 32'(leak), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({tag, "_hold_prod"}, 32'(rsp_o), 32'(a) * 32'(b));
      checkOutput({tag, "_hold_id"}, 32'(rsp_id), 32'(g));
      checkOutput({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k;
    logic leak;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus('0, '0, '0);
    v1  = '0;
    a1  = '0;
    b1  = '0;
    rr1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_rsp_o", 32'(rsp_o), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Constant-time instance: fixed WIDTH steps regardless of operands.
    for (int t = 0; t < 2; t++) begin
      v1 = 4'b0001;
      a1 = (t == 0) ? 16'h0009 : 16'h0003;
      b1 = (t == 0) ? 16'h0000 : 16'h0005;
      #1;
      checkOutput("ct_grant", 32'(rdy1), 32'd1);
      @(negedge clk);
      v1 = '0;
      #1;
      k = 1;
      while (!rv1 && k < 40) begin
        @(negedge clk);
        #1;
        k++;
      end
      checkOutput("ct_lat", 32'(k), 32'(modelSteps(a1[W-1:0], b1[W-1:0], 1'b1) + 2));
      checkOutput("ct_prod", 32'(ro1), 32'(a1[W-1:0]) * 32'(b1[W-1:0]));
      checkOutput("ct_id", 32'(rid1), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("ct_idle", 32'(busy1), 32'd0);
    end

    applyStimulus(4'b0001, 16'h0003, 16'h0005);
    runTxn("dir_3x5", 0);
    applyStimulus(4'b0010, 16'h0090, 16'h0000);
    runTxn("dir_b_zero", 0);
    applyStimulus(4'b0100, 16'h0000, 16'h0c00);
    runTxn("dir_a_zero", 1);

    // All requesters pending: the winner must rotate through every index.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1111, 16'($urandom), 16'($urandom));
      runTxn("rr_all", 0);
    end

    applyStimulus(4'b1111, 16'hffff, 16'hffff);
    runTxn("max_15x15", 0);
    applyStimulus(4'b1111, 16'h7b5d, 16'h39ae);
    runTxn("stall5", 5);
    applyStimulus(4'b1111, 16'h1234, 16'h4321);
    runTxn("after_stall", 0);

    // Reset while the engine is mid-computation.
    applyStimulus(4'b1111, 16'h7777, 16'hffff);
    #1;
    checkOutput("midrst_grant", 32'(req_ready), 32'(1 << modelGrant()));
    @(negedge clk);
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midrst_ready", 32'(req_ready), 32'd0);
    checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midrst_rsp_o", 32'(rsp_o), 32'd0);
    checkOutput("midrst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("midrst_busy_low", 32'(busy), 32'd0);
    rst_n  = 1'b1;
    last_m = NREQ - 1;
    applyStimulus('0, 16'h7777, 16'hffff);
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      leak = leak | rsp_valid | busy;
    end
    checkOutput("midrst_no_stale", 32'(leak), 32'd0);
    applyStimulus(4'b1111, 16'h2468, 16'h1357);
    runTxn("post_rst", 0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom));
      runTxn("rand", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
